// File: rtl/ap_ctrl_initiator.sv
// ap_ctrl_initiator: ap_ctrl_hs initiator feeding (p,q) jobs to a kernel and returning its result.
// Define KERNEL_TIMEOUT_EN to build the watchdog that aborts a job whose done never arrives.
module ap_ctrl_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_p,
  input  logic [DATA_WIDTH-1:0] in_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  k_ap_start,
  input  logic                  k_ap_done,
  input  logic                  k_ap_idle,
  input  logic                  k_ap_ready,
  output logic [DATA_WIDTH-1:0] k_p,
  output logic [DATA_WIDTH-1:0] k_q,
  input  logic [DATA_WIDTH-1:0] k_result,
  output logic [CNT_WIDTH-1:0]  job_count,
  output logic                  err_spurious,
  output logic                  err_timeout
);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, OUTPUT} state_t;
  state_t r_state, w_state_n;
  logic r_start, w_start_n, r_ovld, w_ovld_n, r_done_seen, w_done_seen_n, r_spur, w_spur_n;
  logic [DATA_WIDTH-1:0] r_p, r_q, r_data, w_p_n, w_q_n, w_data_n;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_n;
  logic w_busy, w_tout, w_unused;
  assign w_busy       = (r_state == START) || (r_state == WAIT_DONE);
  assign w_unused     = ^{k_ap_idle, 32'(TIMEOUT_CYCLES)};
  assign in_ready     = (r_state == IDLE);
  assign out_valid    = r_ovld;
  assign out_data     = r_data;
  assign k_ap_start   = r_start;
  assign k_p          = r_p;
  assign k_q          = r_q;
  assign job_count    = r_cnt;
  assign err_spurious = r_spur;
`ifdef KERNEL_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] r_tmr;
  logic r_tout;
  assign w_tout      = w_busy && !r_done_seen && !k_ap_done && (r_tmr == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_tout;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_tmr  <= '0;
      r_tout <= 1'b0;
    end else begin
      r_tmr  <= w_busy ? r_tmr + 1'b1 : '0;
      r_tout <= r_tout | w_tout;
    end
  end
`else
  assign w_tout      = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_comb begin
    w_state_n     = r_state;
    w_start_n     = r_start;
    w_ovld_n      = r_ovld;
    w_done_seen_n = r_done_seen;
    w_p_n         = r_p;
    w_q_n         = r_q;
    w_data_n      = r_data;
    w_cnt_n       = r_cnt;
    w_spur_n      = r_spur | (k_ap_done & (!w_busy | r_done_seen));
    // only the first done of a job is captured; later ones are flagged above
    if (w_busy && k_ap_done && !r_done_seen) begin
      w_data_n      = k_result;
      w_done_seen_n = 1'b1;
    end
    case (r_state)
      IDLE: if (in_valid) begin
        w_p_n     = in_p;
        w_q_n     = in_q;
        w_start_n = 1'b1;
        w_state_n = START;
      end
      START: if (k_ap_ready) begin
        w_start_n = 1'b0;
        w_ovld_n  = r_done_seen | k_ap_done;
        w_state_n = (r_done_seen | k_ap_done) ? OUTPUT : WAIT_DONE;
      end
      WAIT_DONE: if (k_ap_done) begin
        w_ovld_n  = 1'b1;
        w_state_n = OUTPUT;
      end
      OUTPUT: if (out_ready) begin
        w_ovld_n      = 1'b0;
        w_cnt_n       = r_cnt + 1'b1;
        w_done_seen_n = 1'b0;
        w_state_n     = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    if (w_tout) begin
      w_start_n = 1'b0;
      w_data_n  = '1;
      w_ovld_n  = 1'b1;
      w_state_n = OUTPUT;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= IDLE;
      r_start     <= 1'b0;
      r_ovld      <= 1'b0;
      r_done_seen <= 1'b0;
      r_spur      <= 1'b0;
      r_p         <= '0;
      r_q         <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_n;
      r_start     <= w_start_n;
      r_ovld      <= w_ovld_n;
      r_done_seen <= w_done_seen_n;
      r_spur      <= w_spur_n;
      r_p         <= w_p_n;
      r_q         <= w_q_n;
      r_data      <= w_data_n;
      r_cnt       <= w_cnt_n;
    end
  end
endmodule

// File: doc/ap_ctrl_initiator.md
Name: ap_ctrl_initiator

Overview:
- Drives the control side of an HLS-style ap_ctrl_hs compute kernel with a 2-operand (p, q) / 1-result interface; it is the initiator that the kernel answers to.
- Accepts operand pairs from an upstream valid/ready stream, presents them to the kernel, and pulses/holds ap_start per protocol.
- Captures the kernel result on ap_done and offers it on a downstream valid/ready stream.
- Sits between the host-side job queue and each kernel instance on the Alveo U50 build.

Parameters:
- DATA_WIDTH, 32, operand/result width
- CNT_WIDTH, 16, width of job counter and timeout counter
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with KERNEL_TIMEOUT_EN)

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream operand pair valid
- in_ready  out  1  upstream ready; combinational, equals (state==IDLE)
- in_p  in  DATA_WIDTH  operand p
- in_q  in  DATA_WIDTH  operand q
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_WIDTH  captured result
- k_ap_start  out  1  kernel start
- k_ap_done  in  1  kernel done (single-cycle pulse)
- k_ap_idle  in  1  kernel idle (status only, not used for sequencing)
- k_ap_ready  in  1  kernel ready (start consumed)
- k_p  out  DATA_WIDTH  operand p to kernel, registered
- k_q  out  DATA_WIDTH  operand q to kernel, registered
- k_result  in  DATA_WIDTH  kernel result, valid in the k_ap_done cycle
- job_count  out  CNT_WIDTH  completed jobs; wraps modulo 2^CNT_WIDTH
- err_spurious  out  1  sticky: k_ap_done seen in IDLE or OUTPUT
- err_timeout  out  1  sticky watchdog flag; constant 0 without KERNEL_TIMEOUT_EN

Behaviour:
- Reset (ap_rst=1 at an edge):
  - state=IDLE.
  - k_ap_start, out_valid, err_spurious, err_timeout, done_seen = 0.
  - k_p, k_q, out_data, job_count = 0.
  - Reset mid-job abandons the kernel job immediately; no result is produced.
- States: IDLE, START, WAIT_DONE, OUTPUT (2-bit encoding).
- IDLE:
  - On in_valid at the edge: latch in_p/in_q into k_p/k_q.
  - Set k_ap_start=1 and go to START (k_ap_start high from the next cycle).
- START:
  - Hold k_ap_start=1 and keep k_p/k_q stable until k_ap_ready=1 is sampled.
  - At that edge, k_ap_start goes to 0.
  - Next state is OUTPUT if done has already been captured (done_seen, or k_ap_done in the same cycle); otherwise WAIT_DONE.
- k_ap_done in START or WAIT_DONE:
  - Capture k_result into out_data in that cycle.
  - Set done_seen.
  - In WAIT_DONE, move to OUTPUT with out_valid=1 on the next cycle.
  - Only the first done per job is captured; a further done before OUTPUT sets err_spurious.
- OUTPUT:
  - out_valid=1; out_data held stable until out_ready=1.
  - At the out_ready edge: out_valid=0, job_count+1, done_seen=0, go to IDLE.
- in_ready=0 in every state except IDLE. No overlap of jobs.
- Minimum turnaround with a zero-latency kernel (ready and done in the first start cycle):
  - in accept T0, start T1, out_valid T2, accept T2 (out_ready=1), in_ready T3.
  - Throughput is 1 job per 3 cycles.
- k_ap_done sampled in IDLE or OUTPUT sets err_spurious (sticky until reset). This includes a late done from a job abandoned by reset.
- k_ap_idle is ignored for sequencing.

Optional Feature:
- Macro: KERNEL_TIMEOUT_EN.
- Defined:
  - CNT_WIDTH-bit counter clears on entering START and increments each cycle in START/WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES-1 with no done captured: force k_ap_start=0, out_data = all ones, set err_timeout (sticky), go to OUTPUT.
  - The job completes normally downstream and job_count still increments.
  - A later done from the abandoned job sets err_spurious.
- Undefined: no counter is built, err_timeout is tied 0, and the block waits indefinitely for done.

Test Plan:
- Basic: in_p=5, in_q=7, kernel asserts ready 2 cycles after start and done 4 cycles after start with k_result=12 -> k_ap_start high exactly until the ready edge; out_valid with out_data=12; job_count=1.
- Back-pressure: out_ready held 0 for 10 cycles after done -> out_data stays 12, in_ready=0 throughout, in_valid ignored; on release, in_ready returns the cycle after.
- Zero-latency kernel (ready and done in the first start cycle, result 0xDEADBEEF) -> out_valid one cycle after k_ap_start rose; 3-cycle job period sustained over 8 jobs; job_count=8.
- Done before ready (done with result 3 in the first start cycle, ready 2 cycles later) -> out_data=3, OUTPUT entered after ready, err_spurious=0.
- Reset in WAIT_DONE, then kernel done 3 cycles later -> outputs return to reset values, err_spurious=1, no out_valid.
- KERNEL_TIMEOUT_EN, TIMEOUT_CYCLES=16, kernel never done -> k_ap_start=0 and out_valid with out_data=0xFFFFFFFF at cycle 16 after start; err_timeout=1.
